wb_shared_bus_arbiter: RTL and testbench
========================================

Name: wb_shared_bus_arbiter

Overview:
Parametrised N-master to 1-slave Wishbone arbiter. It lets the instruction bridge, data bridge and future masters (DMA, debug) share one slave port, such as the memory controller, without the full crossbar. It supports round-robin or fixed-priority arbitration, holds the grant for a whole cycle, and routes termination signals back per master. Sits between the bus bridges and the slave, on the system clock domain.

Parameters:
NUM_MASTERS, 2, number of master ports (2..8)
DW, 32, data bus width
AW, 32, address bus width
SW, 4, byte-select width (DW/8)
PRIO_MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins)
TIMEOUT_CYCLES, 255, stall limit for the optional watchdog (8-bit counter, 1..255)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous active-low reset
m_cyc_i  in  NUM_MASTERS  per-master cyc
m_stb_i  in  NUM_MASTERS  per-master stb
m_we_i  in  NUM_MASTERS  per-master write enable
m_addr_i  in  NUM_MASTERS*AW  flattened addresses; master k occupies bits [k*AW +: AW]
m_data_i  in  NUM_MASTERS*DW  flattened write data
m_sel_i  in  NUM_MASTERS*SW  flattened byte selects
m_data_o  out  DW  slave read data, broadcast to all masters
m_ack_o  out  NUM_MASTERS  per-master ack
m_err_o  out  NUM_MASTERS  per-master err
m_rty_o  out  NUM_MASTERS  per-master rty
s_cyc_o, s_stb_o, s_we_o  out  1  to slave
s_addr_o  out  AW  to slave
s_data_o  out  DW  to slave
s_sel_o  out  SW  to slave
s_data_i  in  DW  from slave
s_ack_i, s_err_i, s_rty_i  in  1  from slave
gnt_o  out  NUM_MASTERS  one-hot current grant, registered
busy_o  out  1  a grant is held

Behaviour:
- Reset (reset=0, asynchronous):
  - gnt_o=0, busy_o=0, state=IDLE.
  - Round-robin pointer = master 0.
  - All s_* outputs and m_ack/err/rty = 0. s_addr_o/s_data_o/s_sel_o = 0.
  - Reset mid-cycle drops s_cyc_o/s_stb_o immediately.
- FSM has two states: IDLE and OWNED.
  - IDLE: if any m_cyc_i=1, pick a winner. At the next edge: gnt_o=onehot(winner), busy_o=1, go to OWNED.
  - Latency is one clock from request to s_cyc_o.
  - OWNED: the grant is held while the granted master's m_cyc_i=1, regardless of other requests. No preemption, so locked read-modify-write works.
  - OWNED, granted m_cyc_i=0: at the next edge, re-arbitrate among the current requesters. If there is a winner, grant it directly (back-to-back, no idle cycle); otherwise go to IDLE with gnt_o=0.
- Round-robin:
  - Search starts at (last granted + 1) mod NUM_MASTERS.
  - The pointer updates on each new grant.
- Fixed priority: the lowest-index requester wins. Starvation is permitted by design.
- Data path (combinational, selected by gnt_o):
  - s_cyc/stb/we/addr/data/sel = granted master's signals; all 0 when gnt_o=0.
  - m_ack_o[k]=s_ack_i&gnt_o[k]; likewise for err and rty.
  - Non-granted masters always see 0 on ack/err/rty.
- Slave terminations while gnt_o=0 are ignored.
- A request arriving in the same cycle as a release is eligible for that re-arbitration.
- NUM_MASTERS=1 degenerates to a pass-through with one cycle of grant latency.

Optional Feature:
- Macro WB_ARB_TIMEOUT_EN.
- When defined:
  - An 8-bit counter increments each cycle with s_stb_o=1 and no s_ack_i/s_err_i/s_rty_i.
  - The counter clears on any termination, on a grant change, or when stb=0.
  - When count reaches TIMEOUT_CYCLES: m_err_o[granted]=1 for exactly one cycle, s_stb_o forced 0 in that cycle, counter cleared.
  - The grant stays until the master drops cyc.
- When undefined: no counter logic, TIMEOUT_CYCLES is unused, and err comes only from the slave.

Decomposition:
- Package nnarm_wb_pkg:
  - AW/DW/SW defaults.
  - PRIO_MODE encodings (PRIO_RR=0, PRIO_FIXED=1).
  - Arbiter state encoding (IDLE=0, OWNED=1).
  - Timeout counter width constant (8).
- Sub-module wb_arb_pick: combinational rotating priority picker.
  - Inputs: request vector, start pointer, mode.
  - Outputs: one-hot winner and winner index.
  - Reused by a future crossbar.

Test Plan:
- Reset, then m_cyc_i=2'b01 -> gnt_o=01 one clock later; s_addr_o = master0 addr 0x0000_1000; slave ack reaches m_ack_o[0] only.
- RR mode, both masters hold cyc continuously, each releasing after 1 ack -> grants alternate 01,10,01,10 with no idle cycle between grants.
- Fixed mode, both request continuously -> master 0 granted every arbitration; master 1 granted only after master 0 deasserts cyc.
- Master 0 holds cyc over 3 beats (RMW: read 0x20, write 0x20) while master 1 requests -> no grant change until master 0 cyc=0.
- Assert reset mid-transfer with gnt_o=10 -> gnt_o, s_cyc_o and s_stb_o = 0 immediately; after release, arbitration restarts from master 0.
- With WB_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, slave never acks -> m_err_o[granted] pulses at cycle 16 of stb and s_stb_o=0 that cycle; without the macro, stb is held indefinitely.

Source files
------------

// File: rtl/nnarm_wb_pkg.sv
// Shared definitions for the Wishbone N-to-1 arbiter slice.
// Provides bus width defaults, arbitration mode encodings, the arbiter
// state encoding, the watchdog counter width and an index-width helper.
package nnarm_wb_pkg;

    localparam int AW_DEF = 32;
    localparam int DW_DEF = 32;
    localparam int SW_DEF = 4;

    localparam int PRIO_RR    = 0;
    localparam int PRIO_FIXED = 1;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } arb_state_t;

    localparam int TO_CNT_W = 8;

    // Width of a master index; never zero so single-master builds stay legal.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wb_shared_bus_arbiter_if.sv
// Bundle of every Wishbone signal around the shared-bus arbiter.
// m_* : flattened per-master request side (master k at [k*W +: W]).
// s_* : single slave side.
// Modports:
//   slave  - the arbiter's view (it is the slave of the masters and
//            drives the downstream slave port).
//   master - the environment's view (masters plus downstream slave).
interface wb_shared_bus_arbiter_if
    import nnarm_wb_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int AW          = AW_DEF,
    parameter int DW          = DW_DEF,
    parameter int SW          = SW_DEF
);
    logic [NUM_MASTERS-1:0]    m_cyc_i;
    logic [NUM_MASTERS-1:0]    m_stb_i;
    logic [NUM_MASTERS-1:0]    m_we_i;
    logic [NUM_MASTERS*AW-1:0] m_addr_i;
    logic [NUM_MASTERS*DW-1:0] m_data_i;
    logic [NUM_MASTERS*SW-1:0] m_sel_i;
    logic [DW-1:0]             m_data_o;
    logic [NUM_MASTERS-1:0]    m_ack_o;
    logic [NUM_MASTERS-1:0]    m_err_o;
    logic [NUM_MASTERS-1:0]    m_rty_o;

    logic                      s_cyc_o;
    logic                      s_stb_o;
    logic                      s_we_o;
    logic [AW-1:0]             s_addr_o;
    logic [DW-1:0]             s_data_o;
    logic [SW-1:0]             s_sel_o;
    logic [DW-1:0]             s_data_i;
    logic                      s_ack_i;
    logic                      s_err_i;
    logic                      s_rty_i;

    modport slave (
        input  m_cyc_i, m_stb_i, m_we_i, m_addr_i, m_data_i, m_sel_i,
        output m_data_o, m_ack_o, m_err_o, m_rty_o,
        output s_cyc_o, s_stb_o, s_we_o, s_addr_o, s_data_o, s_sel_o,
        input  s_data_i, s_ack_i, s_err_i, s_rty_i
    );

    modport master (
        output m_cyc_i, m_stb_i, m_we_i, m_addr_i, m_data_i, m_sel_i,
        input  m_data_o, m_ack_o, m_err_o, m_rty_o,
        input  s_cyc_o, s_stb_o, s_we_o, s_addr_o, s_data_o, s_sel_o,
        output s_data_i, s_ack_i, s_err_i, s_rty_i
    );

endinterface

// File: rtl/wb_arb_pick.sv
// Combinational rotating-priority picker.
// Ports:
//   req        - request vector
//   start      - index where the search begins (round-robin mode)
//   mode       - 0 round-robin from start, 1 fixed (index 0 first)
//   win_onehot - one-hot winner, zero when nobody requests
//   win_idx    - winner index
//   win_valid  - at least one request present
module wb_arb_pick
    import nnarm_wb_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    input  logic          mode,
    output logic [N-1:0]  win_onehot,
    output logic [IW-1:0] win_idx,
    output logic          win_valid
);

    always_comb begin
        logic [IW-1:0] base;
        logic [IW-1:0] cand;
        win_onehot = '0;
        win_idx    = '0;
        win_valid  = 1'b0;
        base       = (mode == 1'(PRIO_FIXED)) ? '0 : start;
        cand       = '0;
        for (int i = 0; i < N; i++) begin
            cand = IW'((int'(base) + i) % N);
            if (!win_valid && req[cand]) begin
                win_onehot[cand] = 1'b1;
                win_idx          = cand;
                win_valid        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_shared_bus_arbiter.sv
// N-master to 1-slave Wishbone arbiter with cycle-long grant hold.
// Ports:
//   clock, reset - system clock, asynchronous active-low reset
//   bus          - all master/slave Wishbone signals (slave modport)
//   gnt_o        - registered one-hot grant
//   busy_o       - a grant is currently held
// Optional build macro WB_ARB_TIMEOUT_EN adds a stall watchdog that
// terminates a stalled strobe with a one-cycle err after TIMEOUT_CYCLES.
module wb_shared_bus_arbiter
    import nnarm_wb_pkg::*;
#(
    parameter int NUM_MASTERS    = 2,
    parameter int AW             = AW_DEF,
    parameter int DW             = DW_DEF,
    parameter int SW             = SW_DEF,
    parameter int PRIO_MODE      = PRIO_RR,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                   clock,
    input  logic                   reset,
    wb_shared_bus_arbiter_if.slave bus,
    output logic [NUM_MASTERS-1:0] gnt_o,
    output logic                   busy_o
);

    localparam int IW = idx_w(NUM_MASTERS);

    if (NUM_MASTERS < 1 || NUM_MASTERS > 8) begin : g_bad_num_masters
        $error("wb_shared_bus_arbiter: NUM_MASTERS must be 1..8");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > (1 << TO_CNT_W) - 1) begin : g_bad_timeout
        $error("wb_shared_bus_arbiter: TIMEOUT_CYCLES must fit the watchdog counter");
    end

    arb_state_t             state_q, state_d;
    logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
    logic [IW-1:0]          ptr_q, ptr_d;
    logic [NUM_MASTERS-1:0] pick_onehot;
    logic [IW-1:0]          pick_idx;
    logic                   pick_valid;
    logic                   owner_cyc;
    logic                   stb_raw;
    logic                   to_fire;

    wb_arb_pick #(.N(NUM_MASTERS), .IW(IW)) u_pick (
        .req       (bus.m_cyc_i),
        .start     (ptr_q),
        .mode      (PRIO_MODE == PRIO_FIXED),
        .win_onehot(pick_onehot),
        .win_idx   (pick_idx),
        .win_valid (pick_valid)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
        end
    end

    assign owner_cyc = |(bus.m_cyc_i & gnt_q);

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = OWNED;
                    gnt_d   = pick_onehot;
                    ptr_d   = IW'((int'(pick_idx) + 1) % NUM_MASTERS);
                end
            end
            OWNED: begin
                // Owner keeps the bus until it drops cyc; the releasing owner
                // is not requesting, so the picker only sees other masters.
                if (!owner_cyc) begin
                    if (pick_valid) begin
                        gnt_d = pick_onehot;
                        ptr_d = IW'((int'(pick_idx) + 1) % NUM_MASTERS);
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        stb_raw      = 1'b0;
        bus.s_cyc_o  = 1'b0;
        bus.s_we_o   = 1'b0;
        bus.s_addr_o = '0;
        bus.s_data_o = '0;
        bus.s_sel_o  = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (gnt_q[k]) begin
                bus.s_cyc_o  = bus.m_cyc_i[k];
                stb_raw      = bus.m_stb_i[k];
                bus.s_we_o   = bus.m_we_i[k];
                bus.s_addr_o = bus.m_addr_i[k*AW +: AW];
                bus.s_data_o = bus.m_data_i[k*DW +: DW];
                bus.s_sel_o  = bus.m_sel_i[k*SW +: SW];
            end
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    logic [TO_CNT_W-1:0] to_cnt_q;
    logic                term;

    assign term    = bus.s_ack_i | bus.s_err_i | bus.s_rty_i;
    assign to_fire = stb_raw & ~term & (to_cnt_q == TO_CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            to_cnt_q <= '0;
        end else if ((gnt_d != gnt_q) || !stb_raw || term || to_fire) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
        end
    end
`else
    assign to_fire = 1'b0;
`endif

    // The watchdog cycle withdraws the strobe so the slave cannot complete
    // the access in the same cycle the master is told it failed.
    assign bus.s_stb_o  = stb_raw & ~to_fire;
    assign bus.m_data_o = bus.s_data_i;
    assign bus.m_ack_o  = {NUM_MASTERS{bus.s_ack_i}} & gnt_q;
    assign bus.m_err_o  = {NUM_MASTERS{bus.s_err_i | to_fire}} & gnt_q;
    assign bus.m_rty_o  = {NUM_MASTERS{bus.s_rty_i}} & gnt_q;

    assign gnt_o  = gnt_q;
    assign busy_o = (state_q == OWNED);

endmodule

// File: tb/tb_wb_shared_bus_arbiter.sv
module tb_wb_shared_bus_arbiter;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int TO = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] gnt_r, gnt_f;
    logic         busy_r, busy_f;
    logic [1:0]   g, g_nxt;
    logic         fire;
    int           errors = 0;
    int           checks = 0;
    string        tag_q[$];
    logic [63:0]  val_q[$];

    always #5 clk = ~clk;

    wb_shared_bus_arbiter_if #(.NUM_MASTERS(N), .AW(AW), .DW(DW), .SW(SW)) bus_r ();
    wb_shared_bus_arbiter_if #(.NUM_MASTERS(N), .AW(AW), .DW(DW), .SW(SW)) bus_f ();

    wb_shared_bus_arbiter #(
        .NUM_MASTERS(N), .AW(AW), .DW(DW), .SW(SW), .PRIO_MODE(0), .TIMEOUT_CYCLES(TO)
    ) u_rr (
        .clock(clk), .reset(rst_n), .bus(bus_r), .gnt_o(gnt_r), .busy_o(busy_r)
    );

    wb_shared_bus_arbiter #(
        .NUM_MASTERS(N), .AW(AW), .DW(DW), .SW(SW), .PRIO_MODE(1), .TIMEOUT_CYCLES(TO)
    ) u_fix (
        .clock(clk), .reset(rst_n), .bus(bus_f), .gnt_o(gnt_f), .busy_o(busy_f)
    );

    // Both arbiters see identical master and slave stimulus.
    assign bus_f.m_cyc_i  = bus_r.m_cyc_i;
    assign bus_f.m_stb_i  = bus_r.m_stb_i;
    assign bus_f.m_we_i   = bus_r.m_we_i;
    assign bus_f.m_addr_i = bus_r.m_addr_i;
    assign bus_f.m_data_i = bus_r.m_data_i;
    assign bus_f.m_sel_i  = bus_r.m_sel_i;
    assign bus_f.s_data_i = bus_r.s_data_i;
    assign bus_f.s_ack_i  = bus_r.s_ack_i;
    assign bus_f.s_err_i  = bus_r.s_err_i;
    assign bus_f.s_rty_i  = bus_r.s_rty_i;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push(input string tag, input logic [63:0] v);
        tag_q.push_back(tag);
        val_q.push_back(v);
    endtask

    task automatic chk(input logic [63:0] obs);
        string       tag;
        logic [63:0] exp;
        checks++;
        if (tag_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_underflow observed=%0h expected=none", obs);
            return;
        end
        tag = tag_q.pop_front();
        exp = val_q.pop_front();
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_m(input int k, input logic cyc, input logic stb, input logic we,
                         input logic [AW-1:0] addr, input logic [DW-1:0] data);
        bus_r.m_cyc_i[k]            = cyc;
        bus_r.m_stb_i[k]            = stb;
        bus_r.m_we_i[k]             = we;
        bus_r.m_addr_i[k*AW +: AW]  = addr;
        bus_r.m_data_i[k*DW +: DW]  = data;
        bus_r.m_sel_i[k*SW +: SW]   = '1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        bus_r.m_cyc_i  = '0;
        bus_r.m_stb_i  = '0;
        bus_r.m_we_i   = '0;
        bus_r.m_addr_i = '0;
        bus_r.m_data_i = '0;
        bus_r.m_sel_i  = '0;
        bus_r.s_data_i = '0;
        bus_r.s_ack_i  = 1'b0;
        bus_r.s_err_i  = 1'b0;
        bus_r.s_rty_i  = 1'b0;
        rst_n          = 1'b0;
        repeat (2) @(negedge clk);

        // reset state; slave ack during reset must not leak through
        bus_r.s_ack_i = 1'b1;
        #1;
        push("rst_gnt_r", 0);  chk(64'(gnt_r));
        push("rst_gnt_f", 0);  chk(64'(gnt_f));
        push("rst_busy", 0);   chk(64'(busy_r));
        push("rst_s_cyc", 0);  chk(64'(bus_r.s_cyc_o));
        push("rst_s_addr", 0); chk(64'(bus_r.s_addr_o));
        push("rst_m_ack", 0);  chk(64'(bus_r.m_ack_o));
        bus_r.s_ack_i = 1'b0;
        rst_n = 1'b1;
        tick();

        // single master: one-clock grant latency, ack routing
        set_m(0, 1, 1, 0, 32'h0000_1000, '0);
        #1;
        push("t1_gnt_latency", 0); chk(64'(gnt_r));
        push("t1_gnt", 2'b01);
        push("t1_busy", 1);
        push("t1_s_cyc", 1);
        push("t1_s_addr", 32'h0000_1000);
        push("t1_s_sel", 4'hf);
        tick();
        chk(64'(gnt_r)); chk(64'(busy_r)); chk(64'(bus_r.s_cyc_o));
        chk(64'(bus_r.s_addr_o)); chk(64'(bus_r.s_sel_o));
        bus_r.s_ack_i  = 1'b1;
        bus_r.s_data_i = 32'hCAFE_F00D;
        #1;
        push("t1_ack_route", 2'b01);    chk(64'(bus_r.m_ack_o));
        push("t1_rdata", 32'hCAFE_F00D); chk(64'(bus_r.m_data_o));
        tick();
        bus_r.s_ack_i = 1'b0;
        set_m(0, 0, 0, 0, '0, '0);
        push("t1_idle_gnt", 0);
        push("t1_idle_busy", 0);
        tick();
        chk(64'(gnt_r)); chk(64'(busy_r));
        bus_r.s_ack_i = 1'b1;
        bus_r.s_err_i = 1'b1;
        #1;
        push("t1_ignored_ack", 0); chk(64'(bus_r.m_ack_o));
        push("t1_ignored_err", 0); chk(64'(bus_r.m_err_o));
        bus_r.s_ack_i = 1'b0;
        bus_r.s_err_i = 1'b0;

        // round-robin alternation, back-to-back (pointer now at master 1)
        set_m(0, 1, 1, 0, 32'h0000_2000, '0);
        set_m(1, 1, 1, 0, 32'h0000_3000, '0);
        push("t2_gnt", 2'b10);
        tick();
        chk(64'(gnt_r));
        g = 2'b10;
        for (int k = 0; k < 4; k++) begin
            bus_r.s_ack_i = 1'b1;
            #1;
            push("t2_ack_route", 64'(g)); chk(64'(bus_r.m_ack_o));
            tick();
            bus_r.s_ack_i = 1'b0;
            bus_r.m_cyc_i = bus_r.m_cyc_i & ~g;
            bus_r.m_stb_i = bus_r.m_stb_i & ~g;
            g_nxt = ~g;
            push("t2_gnt", 64'(g_nxt));
            tick();
            chk(64'(gnt_r));
            push("t2_no_idle_busy", 1); chk(64'(busy_r));
            bus_r.m_cyc_i = 2'b11;
            bus_r.m_stb_i = 2'b11;
            g = g_nxt;
        end
        bus_r.m_cyc_i = '0;
        bus_r.m_stb_i = '0;
        push("t2_end_idle", 0);
        tick();
        chk(64'(gnt_r));

        // round-robin vs fixed priority on identical requests
        bus_r.m_cyc_i = 2'b11;
        bus_r.m_stb_i = 2'b11;
        push("t3_rr_a", 2'b01); push("t3_fix_a", 2'b01);
        tick();
        chk(64'(gnt_r)); chk(64'(gnt_f));
        bus_r.m_cyc_i = 2'b10;
        bus_r.m_stb_i = 2'b10;
        push("t3_rr_b", 2'b10); push("t3_fix_b", 2'b10);
        tick();
        chk(64'(gnt_r)); chk(64'(gnt_f));
        bus_r.m_cyc_i = 2'b01;
        bus_r.m_stb_i = 2'b01;
        push("t3_rr_same_cycle_req", 2'b01); push("t3_fix_same_cycle_req", 2'b01);
        tick();
        chk(64'(gnt_r)); chk(64'(gnt_f));
        bus_r.m_cyc_i = 2'b00;
        bus_r.m_stb_i = 2'b00;
        push("t3_rr_idle", 0); push("t3_fix_idle", 0);
        tick();
        chk(64'(gnt_r)); chk(64'(gnt_f));
        bus_r.m_cyc_i = 2'b11;
        bus_r.m_stb_i = 2'b11;
        push("t3_rr_rotates", 2'b10); push("t3_fix_lowest_wins", 2'b01);
        tick();
        chk(64'(gnt_r)); chk(64'(gnt_f));
        bus_r.m_cyc_i = 2'b00;
        bus_r.m_stb_i = 2'b00;
        push("t3_rr_end", 0); push("t3_fix_end", 0);
        tick();
        chk(64'(gnt_r)); chk(64'(gnt_f));

        // locked read-modify-write by master 0 while master 1 waits
        set_m(0, 1, 1, 0, 32'h0000_0020, '0);
        push("t4_gnt", 2'b01);
        tick();
        chk(64'(gnt_r));
        set_m(1, 1, 1, 0, 32'h0000_4000, '0);
        bus_r.s_ack_i  = 1'b1;
        bus_r.s_data_i = 32'h0000_1234;
        #1;
        push("t4_rd_ack", 2'b01); chk(64'(bus_r.m_ack_o));
        push("t4_rd_addr", 32'h20); chk(64'(bus_r.s_addr_o));
        push("t4_rd_we", 0); chk(64'(bus_r.s_we_o));
        tick();
        bus_r.s_ack_i = 1'b0;
        set_m(0, 1, 0, 0, 32'h0000_0020, '0);
        push("t4_hold_gap", 2'b01);
        tick();
        chk(64'(gnt_r));
        push("t4_gap_stb", 0); chk(64'(bus_r.s_stb_o));
        set_m(0, 1, 1, 1, 32'h0000_0020, 32'h0000_0055);
        #1;
        push("t4_wr_we", 1); chk(64'(bus_r.s_we_o));
        push("t4_wr_data", 32'h55); chk(64'(bus_r.s_data_o));
        bus_r.s_ack_i = 1'b1;
        push("t4_hold_wr", 2'b01);
        tick();
        chk(64'(gnt_r));
        bus_r.s_ack_i = 1'b0;
        set_m(0, 0, 0, 0, '0, '0);
        push("t4_handover", 2'b10);
        push("t4_m1_addr", 32'h0000_4000);
        tick();
        chk(64'(gnt_r)); chk(64'(bus_r.s_addr_o));

        // asynchronous reset in the middle of master 1's cycle
        set_m(0, 1, 1, 0, 32'h0000_5000, '0);
        rst_n = 1'b0;
        #1;
        push("t5_gnt", 0);   chk(64'(gnt_r));
        push("t5_s_cyc", 0); chk(64'(bus_r.s_cyc_o));
        push("t5_s_stb", 0); chk(64'(bus_r.s_stb_o));
        push("t5_busy", 0);  chk(64'(busy_r));
        tick();
        rst_n = 1'b1;
        push("t5_restart_m0", 2'b01);
        tick();
        chk(64'(gnt_r));
        bus_r.m_cyc_i = '0;
        bus_r.m_stb_i = '0;
        tick();

        // stalled slave: watchdog only in the timeout build
        set_m(0, 1, 1, 0, 32'h0000_0080, '0);
        tick();
        for (int n = 1; n <= 40; n++) begin
`ifdef WB_ARB_TIMEOUT_EN
            fire = (n % TO) == 0;
`else
            fire = 1'b0;
`endif
            push("t6_s_stb", 64'(!fire));           chk(64'(bus_r.s_stb_o));
            push("t6_m_err", fire ? 64'd1 : 64'd0); chk(64'(bus_r.m_err_o));
            tick();
        end
        push("t6_gnt_kept", 2'b01); chk(64'(gnt_r));
        set_m(0, 0, 0, 0, '0, '0);
        push("t6_release", 0);
        tick();
        chk(64'(gnt_r));

        checks++;
        assert (tag_q.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", tag_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
